// File: rtl/l2_core_request_queue_pkg.sv
// Shared L2 request/response packet definitions and core-ID typing used by the
// per-core request queue and its neighbours on the L2 request port.
`ifndef NUM_CORES
`define NUM_CORES 4
`endif

package l2_core_request_queue_pkg;

   localparam int CORE_ID_W = (`NUM_CORES > 1) ? $clog2(`NUM_CORES) : 1;
   localparam int L2_ID_W   = 2;
   localparam int L2_ADDR_W = 26;
   localparam int L2_DATA_W = 32;

   typedef logic [CORE_ID_W-1:0] core_id_t;

   typedef enum logic [1:0] {
      L2REQ_LOAD,
      L2REQ_STORE,
      L2REQ_FLUSH,
      L2REQ_INVALIDATE
   } l2req_op_t;

   typedef enum logic [1:0] {
      L2RSP_LOAD_ACK,
      L2RSP_STORE_ACK,
      L2RSP_FLUSH_ACK,
      L2RSP_INVALIDATE_ACK
   } l2rsp_op_t;

   typedef struct packed {
      logic                 valid;
      core_id_t             core;
      logic [L2_ID_W-1:0]   id;
      l2req_op_t            op;
      logic [L2_ADDR_W-1:0] address;
      logic [L2_DATA_W-1:0] data;
   } l2req_packet_t;

   typedef struct packed {
      logic                 valid;
      logic                 status;
      core_id_t             core;
      logic [L2_ID_W-1:0]   id;
      l2rsp_op_t            op;
      logic [L2_ADDR_W-1:0] address;
      logic [L2_DATA_W-1:0] data;
   } l2rsp_packet_t;

   // A response belongs to a core when it is valid and carries that core's index.
   function automatic logic response_for_core(input l2rsp_packet_t rsp, input core_id_t core);
      return rsp.valid && (rsp.core == core);
   endfunction

endpackage

// File: rtl/l2_core_request_queue_sync_fifo.sv
// Generic synchronous FIFO with an occupancy count; the caller guarantees it
// never pushes when full nor pops when empty.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int SIZE  = 4
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   push,
   input  logic [WIDTH-1:0]       push_data,
   input  logic                   pop,
   output logic [WIDTH-1:0]       head,
   output logic [$clog2(SIZE):0]  count
);

   localparam int PTR_W = $clog2(SIZE);

   logic [WIDTH-1:0] mem [SIZE];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Storage carries no reset; only pointers and count define what is valid.
   always_ff @(posedge clk) begin
      if (push)
         mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push)
            wr_ptr <= wr_ptr + 1'b1;
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/l2_core_request_queue.sv
// Per-core request FIFO in front of the L2 request port, throttled by a credit
// count of requests issued but not yet answered by an L2 response.
module l2_core_request_queue
   import l2_core_request_queue_pkg::*;
#(
   parameter int CORE_ID         = 0,
   parameter int FIFO_DEPTH      = 4,
   parameter int MAX_OUTSTANDING = 8
) (
   input  logic                             clk,
   input  logic                             reset,
   input  l2req_packet_t                    enq_request,
   output logic                             enq_ready,
   output l2req_packet_t                    l2i_request,
   input  logic                             l2_ready,
   input  l2rsp_packet_t                    l2_response,
   output logic [$clog2(FIFO_DEPTH):0]      queue_count,
   output logic [$clog2(MAX_OUTSTANDING):0] outstanding_count,
   output logic                             perf_queue_full
);

   localparam int QCNT_W = $clog2(FIFO_DEPTH) + 1;
   localparam int OCNT_W = $clog2(MAX_OUTSTANDING) + 1;
   localparam logic [QCNT_W-1:0] QUEUE_FULL = QCNT_W'(FIFO_DEPTH);
   localparam logic [OCNT_W-1:0] OUT_LIMIT  = OCNT_W'(MAX_OUTSTANDING);
   localparam core_id_t          MY_CORE    = core_id_t'(CORE_ID);

   l2req_packet_t head;
   logic          push;
   logic          pop;
   logic          issue_valid;
   logic          rsp_match;
   logic          credit_return;

   // enq_ready depends only on the registered count, never on l2_ready.
   assign enq_ready       = (queue_count != QUEUE_FULL);
   assign push            = enq_request.valid && enq_ready;
   assign perf_queue_full = enq_request.valid && !enq_ready;

   assign issue_valid = (queue_count != '0) && (outstanding_count != OUT_LIMIT);
   assign pop         = issue_valid && l2_ready;

   sync_fifo #(
      .WIDTH ($bits(l2req_packet_t)),
      .SIZE  (FIFO_DEPTH)
   ) request_fifo (
      .clk       (clk),
      .reset     (reset),
      .push      (push),
      .push_data (enq_request),
      .pop       (pop),
      .head      (head),
      .count     (queue_count)
   );

   always_comb begin
      l2i_request       = head;
      l2i_request.valid = issue_valid;
   end

   // A response with nothing outstanding belongs to a request from before a
   // reset; dropping it keeps the credit count from going negative.
   assign rsp_match     = response_for_core(l2_response, MY_CORE);
   assign credit_return = rsp_match && (outstanding_count != '0);

   always_ff @(posedge clk) begin
      if (reset) begin
         outstanding_count <= '0;
      end else begin
         case ({pop, credit_return})
            2'b10:   outstanding_count <= outstanding_count + 1'b1;
            2'b01:   outstanding_count <= outstanding_count - 1'b1;
            default: outstanding_count <= outstanding_count;
         endcase
      end
   end

`ifndef SYNTHESIS
   always_ff @(posedge clk) begin
      if (!reset && rsp_match)
         assert (outstanding_count != '0)
         else $warning("l2_core_request_queue core %0d: response with no request outstanding ignored", CORE_ID);
   end
`endif

   logic unused_fields;
   assign unused_fields = ^{head.valid, l2_response.status, l2_response.id, l2_response.op,
                            l2_response.address, l2_response.data};

endmodule

// File: tb/tb_l2_core_request_queue.sv
// Directed bench for l2_core_request_queue: one instance with an 8-deep credit
// limit and one with a 2-deep limit share the same stimulus.
module tb_l2_core_request_queue;
   import l2_core_request_queue_pkg::*;

   logic          clk = 1'b0;
   logic          reset;
   l2req_packet_t req;
   logic          rdy;
   l2rsp_packet_t rsp;

   logic          enq_ready_a, enq_ready_b;
   logic          perf_a, perf_b;
   l2req_packet_t l2i_a, l2i_b;
   logic [2:0]    qc_a, qc_b;
   logic [3:0]    oc_a;
   logic [1:0]    oc_b;

   int checks   = 0;
   int failures = 0;

   always #5 clk = ~clk;

   l2_core_request_queue #(.CORE_ID(0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(8)) dut_a (
      .clk(clk), .reset(reset), .enq_request(req), .enq_ready(enq_ready_a),
      .l2i_request(l2i_a), .l2_ready(rdy), .l2_response(rsp),
      .queue_count(qc_a), .outstanding_count(oc_a), .perf_queue_full(perf_a));

   l2_core_request_queue #(.CORE_ID(0), .FIFO_DEPTH(4), .MAX_OUTSTANDING(2)) dut_b (
      .clk(clk), .reset(reset), .enq_request(req), .enq_ready(enq_ready_b),
      .l2i_request(l2i_b), .l2_ready(rdy), .l2_response(rsp),
      .queue_count(qc_b), .outstanding_count(oc_b), .perf_queue_full(perf_b));

   function automatic l2req_packet_t mk_req(input int n);
      l2req_packet_t p;
      p         = '0;
      p.valid   = 1'b1;
      p.core    = core_id_t'(0);
      p.id      = 2'(n);
      p.op      = L2REQ_STORE;
      p.address = 26'(32'h100 + n * 16);
      p.data    = 32'hA000_0000 + 32'(n);
      return p;
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic set_rsp(input logic v, input int core);
      rsp       = '0;
      rsp.valid = v;
      rsp.core  = core_id_t'(core);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "bench did not finish");
   end

   initial begin
      reset = 1'b1;
      req   = '0;
      rdy   = 1'b0;
      set_rsp(1'b0, 0);
      tick();
      tick();
      reset = 1'b0;
      settle();
      chk("rst_qcount", qc_a, 0);
      chk("rst_outstanding", oc_a, 0);
      chk("rst_enq_ready", enq_ready_a, 1);
      chk("rst_perf_full", perf_a, 0);
      chk("rst_valid", l2i_a.valid, 0);

      // Test 1: push A,B,C then issue in order
      req = mk_req(1);
      tick();
      req = mk_req(2);
      settle();
      chk("t1_valid_after_A", l2i_a.valid, 1);
      chk("t1_head_A", l2i_a.data, mk_req(1).data);
      chk("t1_count_1", qc_a, 1);
      tick();
      req = mk_req(3);
      tick();
      req = '0;
      settle();
      chk("t1_count_3", qc_a, 3);
      chk("t1_head_still_A", l2i_a.data, mk_req(1).data);
      chk("t1_out_0", oc_a, 0);
      rdy = 1'b1;
      tick();
      chk("t1_head_B", l2i_a.data, mk_req(2).data);
      chk("t1_out_1", oc_a, 1);
      tick();
      chk("t1_head_C", l2i_a.data, mk_req(3).data);
      tick();
      rdy = 1'b0;
      settle();
      chk("t1_out_3", oc_a, 3);
      chk("t1_count_0", qc_a, 0);
      chk("t1_valid_0", l2i_a.valid, 0);

      // Test 2: fill a 4-deep queue and push a fifth
      for (int i = 4; i < 8; i++) begin
         req = mk_req(i);
         settle();
         chk("t2_ready_before_push", enq_ready_a, 1);
         chk("t2_perf_idle", perf_a, 0);
         tick();
      end
      req = mk_req(8);
      settle();
      chk("t2_ready_full", enq_ready_a, 0);
      chk("t2_count_4", qc_a, 4);
      chk("t2_perf_pulse", perf_a, 1);
      tick();
      req = '0;
      settle();
      chk("t2_perf_cleared", perf_a, 0);
      chk("t2_count_still_4", qc_a, 4);
      chk("t2_head_first", l2i_a.data, mk_req(4).data);

      // Test 3: credit limit of 2 on dut_b
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 9; i < 12; i++) begin
         req = mk_req(i);
         tick();
      end
      req = '0;
      rdy = 1'b1;
      tick();
      tick();
      chk("t3_b_out_2", oc_b, 2);
      chk("t3_b_valid_0", l2i_b.valid, 0);
      chk("t3_b_count_1", qc_b, 1);
      tick();
      chk("t3_b_blocked", l2i_b.valid, 0);
      chk("t3_b_count_held", qc_b, 1);
      set_rsp(1'b1, 0);
      tick();
      set_rsp(1'b0, 0);
      settle();
      chk("t3_b_out_1", oc_b, 1);
      chk("t3_b_valid_1", l2i_b.valid, 1);
      chk("t3_b_head_third", l2i_b.data, mk_req(11).data);
      tick();
      chk("t3_b_out_2_again", oc_b, 2);
      chk("t3_b_count_0", qc_b, 0);
      rdy = 1'b0;

      // Test 4: simultaneous pop/response and push/pop on dut_a
      reset = 1'b1;
      tick();
      reset = 1'b0;
      for (int i = 12; i < 15; i++) begin
         req = mk_req(i);
         tick();
      end
      req = '0;
      rdy = 1'b1;
      tick();
      chk("t4_out_1", oc_a, 1);
      chk("t4_count_2", qc_a, 2);
      set_rsp(1'b1, 0);
      tick();
      set_rsp(1'b0, 0);
      rdy = 1'b0;
      settle();
      chk("t4_pop_rsp_out_1", oc_a, 1);
      chk("t4_pop_rsp_count_1", qc_a, 1);
      chk("t4_head_14", l2i_a.data, mk_req(14).data);
      req = mk_req(15);
      tick();
      req = mk_req(16);
      rdy = 1'b1;
      tick();
      req = '0;
      rdy = 1'b0;
      settle();
      chk("t4_push_pop_count_2", qc_a, 2);
      chk("t4_push_pop_out_2", oc_a, 2);
      chk("t4_head_15", l2i_a.data, mk_req(15).data);

      // Test 5: foreign-core response and spurious response
      set_rsp(1'b1, 1);
      tick();
      set_rsp(1'b0, 0);
      settle();
      chk("t5_foreign_rsp", oc_a, 2);
      set_rsp(1'b1, 0);
      tick();
      tick();
      settle();
      chk("t5_out_0", oc_a, 0);
      tick();
      set_rsp(1'b0, 0);
      settle();
      chk("t5_no_underflow", oc_a, 0);

      // Test 6: reset with 3 queued and 2 outstanding
      req = mk_req(17);
      tick();
      req = mk_req(18);
      rdy = 1'b1;
      tick();
      req = mk_req(19);
      tick();
      req = '0;
      rdy = 1'b0;
      settle();
      chk("t6_pre_count_3", qc_a, 3);
      chk("t6_pre_out_2", oc_a, 2);
      reset = 1'b1;
      set_rsp(1'b1, 0);
      tick();
      reset = 1'b0;
      settle();
      chk("t6_rst_count", qc_a, 0);
      chk("t6_rst_out", oc_a, 0);
      chk("t6_rst_valid", l2i_a.valid, 0);
      chk("t6_rst_ready", enq_ready_a, 1);
      tick();
      set_rsp(1'b0, 0);
      settle();
      chk("t6_stale_rsp_ignored", oc_a, 0);
      req = mk_req(20);
      tick();
      req = '0;
      settle();
      chk("t6_D_valid", l2i_a.valid, 1);
      chk("t6_D_head", l2i_a.data, mk_req(20).data);
      chk("t6_D_count", qc_a, 1);
      rdy = 1'b1;
      tick();
      rdy = 1'b0;
      settle();
      chk("t6_D_issued_out", oc_a, 1);
      chk("t6_D_issued_count", qc_a, 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
